// File: rtl/core.sv
// Shared constants for the core debug register block: debug register
// indices, STATUS bit layout, the EDBGDTR system register selector and
// a helper that assembles the STATUS word.
package core;

    // Debug register indices (zero-extended to 32 bits for width-safe compares)
    localparam logic [31:0] DBGI_STATUS   = 32'd0;
    localparam logic [31:0] DBGI_DTR_LO   = 32'd1;
    localparam logic [31:0] DBGI_DTR_HI   = 32'd2;
    localparam logic [31:0] DBGI_DTRTX_LO = 32'd3;
    localparam logic [31:0] DBGI_DTRTX_HI = 32'd4;
    localparam logic [31:0] DBGI_ITR3     = 32'd5;

    // STATUS bit positions
    localparam int ST_RX_FULL   = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_ITR_EMPTY = 2;
    localparam int ST_ITR_FULL  = 3;
    localparam int ST_ITR_OVF   = 4;
    localparam int ST_RX_UNDR   = 5;
    localparam int ST_TX_OVF    = 6;
    localparam int ST_OCC_LSB   = 8;

    // System register selector of the debug data transfer register
    localparam logic [2:0] EDBGDTR_REGNUM = 3'd7;
    localparam logic [1:0] EDBGDTR_PLEVEL = 2'd0;

    // Sticky error flags, cleared only by reset or write-1-to-clear
    typedef struct packed {
        logic tx_ovf;
        logic rx_undr;
        logic itr_ovf;
    } sticky_t;

    function automatic logic [31:0] status_word(
        input logic    rx_full,
        input logic    tx_full,
        input logic    itr_empty,
        input logic    itr_full,
        input sticky_t st,
        input logic [7:0] occ
    );
        logic [31:0] s;
        s                   = '0;
        s[ST_RX_FULL]       = rx_full;
        s[ST_TX_FULL]       = tx_full;
        s[ST_ITR_EMPTY]     = itr_empty;
        s[ST_ITR_FULL]      = itr_full;
        s[ST_ITR_OVF]       = st.itr_ovf;
        s[ST_RX_UNDR]       = st.rx_undr;
        s[ST_TX_OVF]        = st.tx_ovf;
        s[ST_OCC_LSB +: 8]  = occ;
        return s;
    endfunction

endpackage

// File: rtl/core_dbg_regs_if.sv
// Bus bundle of the debug register block: debug host port, instruction
// transfer (fetch) port and the system-register read/write ports.
interface core_dbg_regs_if #(
    parameter int DBG_ADDR_WIDTH = 5,
    parameter int DBG_DATA_WIDTH = 32,
    parameter int REG_WIDTH      = 64
);
    // Debug host side
    logic                      dbg_req;
    logic                      dbg_wr_rd;
    logic [DBG_ADDR_WIDTH-1:0] dbg_addr;
    logic [DBG_DATA_WIDTH-1:0] dbg_wdata;
    logic [DBG_DATA_WIDTH-1:0] dbg_rdata;
    logic                      dbg_rd_ready;
    // Fetch side
    logic                      itr_valid;
    logic [31:0]               itr_insn;
    logic                      itr_ready;
    // System register read
    logic                      sreg_rd_en;
    logic [2:0]                sreg_rd_regnum;
    logic [1:0]                sreg_rd_plevel;
    logic                      sreg_rd_valid;
    logic [REG_WIDTH-1:0]      sreg_rd_val;
    // System register write
    logic                      sreg_wr_en;
    logic [2:0]                sreg_wr_regnum;
    logic [1:0]                sreg_wr_plevel;
    logic [REG_WIDTH-1:0]      sreg_wr_val;

    modport master (
        output dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, itr_ready,
        output sreg_rd_en, sreg_rd_regnum, sreg_rd_plevel,
        output sreg_wr_en, sreg_wr_regnum, sreg_wr_plevel, sreg_wr_val,
        input  dbg_rdata, dbg_rd_ready, itr_valid, itr_insn,
        input  sreg_rd_valid, sreg_rd_val
    );

    modport slave (
        input  dbg_req, dbg_wr_rd, dbg_addr, dbg_wdata, itr_ready,
        input  sreg_rd_en, sreg_rd_regnum, sreg_rd_plevel,
        input  sreg_wr_en, sreg_wr_regnum, sreg_wr_plevel, sreg_wr_val,
        output dbg_rdata, dbg_rd_ready, itr_valid, itr_insn,
        output sreg_rd_valid, sreg_rd_val
    );
endinterface

// File: rtl/dbg_itr_fifo.sv
// Instruction transfer queue: power-of-two depth circular buffer with a
// combinational head. A push into a full queue is accepted when a pop
// happens in the same cycle. Storage is not reset; pointers and count are.
module dbg_itr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers, cleared by reset so queued entries are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/core_dbg_regs.sv
// Core debug register block: a plain register bank for the debug host,
// the instruction transfer queue (ITR3), and the two-way DTR mailbox
// between the host and the core's EDBGDTR system register.
module core_dbg_regs
    import core::*;
#(
    parameter int DBG_ADDR_WIDTH = 5,
    parameter int DBG_DATA_WIDTH = 32,
    parameter int ITR_DEPTH      = 4,
    parameter int REG_WIDTH      = 64
) (
    input logic            clk,
    input logic            rst_n,
    core_dbg_regs_if.slave bus
);
    localparam int BANK_SIZE = 2 ** DBG_ADDR_WIDTH;
    localparam int CW        = $clog2(ITR_DEPTH) + 1;

    // Request decode
    logic [31:0] addr_ext;
    logic        dbg_wr, dbg_rd;
    logic        is_status, is_dtr_lo, is_dtr_hi, is_dtrtx_lo, is_dtrtx_hi, is_itr3, is_plain;
    logic        sreg_rd_hit, sreg_wr_hit;

    assign addr_ext    = 32'(bus.dbg_addr);
    assign dbg_wr      = bus.dbg_req &  bus.dbg_wr_rd;
    assign dbg_rd      = bus.dbg_req & ~bus.dbg_wr_rd;
    assign is_status   = (addr_ext == DBGI_STATUS);
    assign is_dtr_lo   = (addr_ext == DBGI_DTR_LO);
    assign is_dtr_hi   = (addr_ext == DBGI_DTR_HI);
    assign is_dtrtx_lo = (addr_ext == DBGI_DTRTX_LO);
    assign is_dtrtx_hi = (addr_ext == DBGI_DTRTX_HI);
    assign is_itr3     = (addr_ext == DBGI_ITR3);
    assign is_plain    = ~(is_status | is_dtr_lo | is_dtr_hi | is_dtrtx_lo | is_dtrtx_hi | is_itr3);
    assign sreg_rd_hit = bus.sreg_rd_en && (bus.sreg_rd_regnum == EDBGDTR_REGNUM)
                                        && (bus.sreg_rd_plevel == EDBGDTR_PLEVEL);
    assign sreg_wr_hit = bus.sreg_wr_en && (bus.sreg_wr_regnum == EDBGDTR_REGNUM)
                                        && (bus.sreg_wr_plevel == EDBGDTR_PLEVEL);

    // Storage (not reset)
    logic [DBG_DATA_WIDTH-1:0] bank_mem [BANK_SIZE];
    logic [DBG_DATA_WIDTH-1:0] dtr_lo_q, dtr_hi_q, dtrtx_lo_q, dtrtx_hi_q;
    // Per-index "written since reset" flags make unwritten indices read 0
    // without having to clear the bank contents themselves.
    logic [BANK_SIZE-1:0]      bank_written_q;

    // Control state (reset)
    logic                      rx_full_q, rx_full_d;
    logic                      tx_full_q, tx_full_d;
    sticky_t                   sticky_q, sticky_d;
    logic [DBG_DATA_WIDTH-1:0] dbg_rdata_q, rd_mux;
    logic                      dbg_rd_ready_q;
    logic                      sreg_rd_valid_q;
    logic [REG_WIDTH-1:0]      sreg_rd_val_q;

    // ITR queue
    logic          itr_push, itr_pop, itr_full, itr_empty;
    logic [31:0]   itr_head;
    logic [CW-1:0] itr_count;
    logic          host_tx_rd, tx_accept;

    assign itr_push   = dbg_wr & is_itr3;
    assign itr_pop    = ~itr_empty & bus.itr_ready;
    assign host_tx_rd = dbg_rd & is_dtrtx_hi;
    // A host read of DTRTX_HI in the same cycle frees the mailbox for the core write
    assign tx_accept  = sreg_wr_hit & (~tx_full_q | host_tx_rd);

    dbg_itr_fifo #(
        .WIDTH (32),
        .DEPTH (ITR_DEPTH)
    ) u_itr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (itr_push),
        .push_data_i (32'(bus.dbg_wdata)),
        .pop_i       (itr_pop),
        .head_o      (itr_head),
        .full_o      (itr_full),
        .empty_o     (itr_empty),
        .count_o     (itr_count)
    );

    // Mailbox flags and sticky errors next state; a set in the same cycle beats a clear
    always_comb begin
        rx_full_d = rx_full_q;
        tx_full_d = tx_full_q;
        sticky_d  = sticky_q;
        if (dbg_wr && is_dtr_hi)  rx_full_d = 1'b1;
        else if (sreg_rd_hit)     rx_full_d = 1'b0;
        if (tx_accept)            tx_full_d = 1'b1;
        else if (host_tx_rd)      tx_full_d = 1'b0;
        if (dbg_wr && is_status) begin
            if (bus.dbg_wdata[ST_ITR_OVF]) sticky_d.itr_ovf = 1'b0;
            if (bus.dbg_wdata[ST_RX_UNDR]) sticky_d.rx_undr = 1'b0;
            if (bus.dbg_wdata[ST_TX_OVF])  sticky_d.tx_ovf  = 1'b0;
        end
        if (itr_push && itr_full && !itr_pop) sticky_d.itr_ovf = 1'b1;
        if (sreg_rd_hit && !rx_full_q)        sticky_d.rx_undr = 1'b1;
        if (sreg_wr_hit && !tx_accept)        sticky_d.tx_ovf  = 1'b1;
    end

    // Debug read data selection
    always_comb begin
        rd_mux = '0;
        if (is_status)
            rd_mux = DBG_DATA_WIDTH'(status_word(rx_full_q, tx_full_q, itr_empty, itr_full,
                                                 sticky_q, 8'(itr_count)));
        else if (is_dtr_lo)   rd_mux = dtr_lo_q;
        else if (is_dtr_hi)   rd_mux = dtr_hi_q;
        else if (is_dtrtx_lo) rd_mux = dtrtx_lo_q;
        else if (is_dtrtx_hi) rd_mux = dtrtx_hi_q;
        else if (is_plain && bank_written_q[bus.dbg_addr])
            rd_mux = bank_mem[bus.dbg_addr];
    end

    // Control registers and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full_q       <= 1'b0;
            tx_full_q       <= 1'b0;
            sticky_q        <= '0;
            dbg_rdata_q     <= '0;
            dbg_rd_ready_q  <= 1'b0;
            sreg_rd_valid_q <= 1'b0;
            sreg_rd_val_q   <= '0;
            bank_written_q  <= '0;
        end else begin
            rx_full_q       <= rx_full_d;
            tx_full_q       <= tx_full_d;
            sticky_q        <= sticky_d;
            dbg_rd_ready_q  <= dbg_rd;
            sreg_rd_valid_q <= sreg_rd_hit;
            if (dbg_rd)      dbg_rdata_q   <= rd_mux;
            if (sreg_rd_hit) sreg_rd_val_q <= REG_WIDTH'({dtr_hi_q, dtr_lo_q});
            if (dbg_wr && is_plain) bank_written_q[bus.dbg_addr] <= 1'b1;
        end
    end

    // Bank and mailbox data storage
    always_ff @(posedge clk) begin
        if (dbg_wr && is_plain)  bank_mem[bus.dbg_addr] <= bus.dbg_wdata;
        if (dbg_wr && is_dtr_lo) dtr_lo_q <= bus.dbg_wdata;
        if (dbg_wr && is_dtr_hi) dtr_hi_q <= bus.dbg_wdata;
        if (tx_accept) begin
            dtrtx_lo_q <= bus.sreg_wr_val[DBG_DATA_WIDTH-1:0];
            dtrtx_hi_q <= bus.sreg_wr_val[2*DBG_DATA_WIDTH-1:DBG_DATA_WIDTH];
        end
    end

    assign bus.dbg_rdata     = dbg_rdata_q;
    assign bus.dbg_rd_ready  = dbg_rd_ready_q;
    assign bus.itr_valid     = ~itr_empty;
    assign bus.itr_insn      = itr_head;
    assign bus.sreg_rd_valid = sreg_rd_valid_q;
    assign bus.sreg_rd_val   = sreg_rd_val_q;
endmodule

// File: tb/tb_core_dbg_regs.sv
// Testbench for core_dbg_regs: scenario tasks with scoreboard queues for
// debug reads, core DTR reads and ITR instructions.
module tb_core_dbg_regs;
    import core::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_dbg_regs_if #(.DBG_ADDR_WIDTH(5), .DBG_DATA_WIDTH(32), .REG_WIDTH(64)) bus ();

    core_dbg_regs #(
        .DBG_ADDR_WIDTH (5),
        .DBG_DATA_WIDTH (32),
        .ITR_DEPTH      (4),
        .REG_WIDTH      (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_exp_q[$];
    logic [63:0] sreg_exp_q[$];
    logic [31:0] itr_exp_q[$];
    int          model_itr_cnt = 0;

    logic [4:0] A_STATUS, A_DTR_LO, A_DTR_HI, A_TX_LO, A_TX_HI, A_ITR3;

    // ---------------- basic bus operations ----------------
    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b1; bus.dbg_addr = a; bus.dbg_wdata = d;
        @(negedge clk);
        bus.dbg_req = 1'b0; bus.dbg_wr_rd = 1'b0;
        $display("dbg write  addr=%0d data=%h", a, d);
    endtask

    // ITR3 push with a bench-side queue model (itr_ready held low)
    task automatic itr_push(input logic [31:0] d);
        if (model_itr_cnt < 4) begin
            itr_exp_q.push_back(d);
            model_itr_cnt++;
        end
        dbg_write(A_ITR3, d);
    endtask

    task automatic dbg_read_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        int waited;
        logic [31:0] e;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b0; bus.dbg_addr = a;
        checks++;
        if (bus.dbg_rd_ready !== 1'b0) begin
            errors++; $display("FAIL %s_early: rd_ready=%b required 0", name, bus.dbg_rd_ready);
        end
        @(negedge clk);
        bus.dbg_req = 1'b0;
        waited = 0;
        while (bus.dbg_rd_ready !== 1'b1 && waited < 4) begin
            @(negedge clk); waited++;
        end
        e = rd_exp_q.pop_front();
        checks++;
        if (waited != 0) begin
            errors++; $display("FAIL %s_latency: extra cycles=%0d required 0", name, waited);
        end
        checks++;
        if (bus.dbg_rdata !== e) begin
            errors++; $display("FAIL %s_data: rdata=%h required %h", name, bus.dbg_rdata, e);
        end
        $display("dbg read   addr=%0d data=%h exp=%h", a, bus.dbg_rdata, e);
        @(negedge clk);
        checks++;
        if (bus.dbg_rd_ready !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: rd_ready=%b required 0", name, bus.dbg_rd_ready);
        end
    endtask

    task automatic sreg_write(input logic [2:0] rn, input logic [1:0] pl, input logic [63:0] v);
        @(negedge clk);
        bus.sreg_wr_en = 1'b1; bus.sreg_wr_regnum = rn; bus.sreg_wr_plevel = pl; bus.sreg_wr_val = v;
        @(negedge clk);
        bus.sreg_wr_en = 1'b0;
        $display("sreg write regnum=%0d pl=%0d val=%h", rn, pl, v);
    endtask

    task automatic sreg_read_chk(input logic [63:0] exp, input string name);
        logic [63:0] e;
        sreg_exp_q.push_back(exp);
        @(negedge clk);
        bus.sreg_rd_en = 1'b1; bus.sreg_rd_regnum = 3'd7; bus.sreg_rd_plevel = 2'd0;
        @(negedge clk);
        bus.sreg_rd_en = 1'b0;
        e = sreg_exp_q.pop_front();
        checks++;
        if (bus.sreg_rd_valid !== 1'b1 || bus.sreg_rd_val !== e) begin
            errors++;
            $display("FAIL %s: valid=%b val=%h required valid=1 val=%h", name, bus.sreg_rd_valid, bus.sreg_rd_val, e);
        end
        $display("sreg read  val=%h exp=%h", bus.sreg_rd_val, e);
        @(negedge clk);
        checks++;
        if (bus.sreg_rd_valid !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: valid=%b required 0", name, bus.sreg_rd_valid);
        end
    endtask

    task automatic sreg_read_miss(input logic [2:0] rn, input logic [1:0] pl, input string name);
        @(negedge clk);
        bus.sreg_rd_en = 1'b1; bus.sreg_rd_regnum = rn; bus.sreg_rd_plevel = pl;
        @(negedge clk);
        bus.sreg_rd_en = 1'b0;
        checks++;
        if (bus.sreg_rd_valid !== 1'b0) begin
            errors++; $display("FAIL %s: valid=%b required 0", name, bus.sreg_rd_valid);
        end
        $display("sreg read  regnum=%0d pl=%0d (no response expected)", rn, pl);
    endtask

    // Drain the ITR queue with itr_ready high, one instruction per cycle
    task automatic itr_drain_chk(input string name);
        logic [31:0] e;
        @(negedge clk);
        bus.itr_ready = 1'b1;
        while (itr_exp_q.size() > 0) begin
            e = itr_exp_q.pop_front();
            checks++;
            if (bus.itr_valid !== 1'b1 || bus.itr_insn !== e) begin
                errors++;
                $display("FAIL %s: valid=%b insn=%h required valid=1 insn=%h", name, bus.itr_valid, bus.itr_insn, e);
            end
            $display("itr fetch  insn=%h exp=%h", bus.itr_insn, e);
            @(negedge clk);
        end
        checks++;
        if (bus.itr_valid !== 1'b0) begin
            errors++; $display("FAIL %s_empty: itr_valid=%b required 0", name, bus.itr_valid);
        end
        bus.itr_ready = 1'b0;
        model_itr_cnt = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (bus.dbg_rd_ready !== 1'b0 || bus.dbg_rdata !== 32'h0 || bus.itr_valid !== 1'b0 ||
            bus.sreg_rd_valid !== 1'b0 || bus.sreg_rd_val !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b rdata=%h itrv=%b srv=%b srval=%h required all 0",
                     bus.dbg_rd_ready, bus.dbg_rdata, bus.itr_valid, bus.sreg_rd_valid, bus.sreg_rd_val);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
        dbg_read_chk(A_STATUS, 32'h0000_0004, "reset_status");
        dbg_read_chk(5'd12, 32'h0, "unwritten_idx");
    endtask

    task automatic test_bank();
        dbg_write(5'd9, 32'hDEAD_BEEF);
        dbg_write(5'd20, 32'h1234_5678);
        dbg_read_chk(5'd9, 32'hDEAD_BEEF, "bank_idx9");
        dbg_read_chk(5'd20, 32'h1234_5678, "bank_idx20");
        dbg_read_chk(5'd31, 32'h0, "bank_idx31_unwritten");
    endtask

    task automatic test_itr_overflow();
        bus.itr_ready = 1'b0;
        for (int i = 1; i <= 5; i++) itr_push(32'(i));
        dbg_read_chk(A_STATUS, 32'h0000_0418, "itr_ovf_status");
        itr_drain_chk("itr_ovf_drain");
        dbg_write(A_STATUS, 32'h10);
        dbg_read_chk(A_STATUS, 32'h0000_0004, "itr_ovf_cleared");
    endtask

    task automatic test_itr_push_pop_full();
        for (int i = 0; i < 4; i++) itr_push(32'h11 + 32'(i));
        // Push while full with a simultaneous pop: must be accepted
        @(negedge clk);
        bus.itr_ready = 1'b1;
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b1; bus.dbg_addr = A_ITR3; bus.dbg_wdata = 32'h99;
        void'(itr_exp_q.pop_front());
        itr_exp_q.push_back(32'h99);
        @(negedge clk);
        bus.itr_ready = 1'b0; bus.dbg_req = 1'b0; bus.dbg_wr_rd = 1'b0;
        $display("itr push 99 with simultaneous pop");
        dbg_read_chk(A_STATUS, 32'h0000_0408, "itr_full_pushpop_status");
        itr_drain_chk("itr_pushpop_drain");
    endtask

    task automatic test_dtr_rx();
        logic [63:0] e;
        dbg_write(A_DTR_LO, 32'h1111_1111);
        dbg_write(A_DTR_HI, 32'h2222_2222);
        dbg_read_chk(A_STATUS, 32'h0000_0005, "rx_full_set");
        sreg_read_miss(3'd6, 2'd0, "sreg_rd_regnum6");
        sreg_read_miss(3'd7, 2'd1, "sreg_rd_plevel1");
        dbg_read_chk(A_STATUS, 32'h0000_0005, "rx_full_after_miss");
        sreg_read_chk(64'h2222_2222_1111_1111, "dtr_rx_read");
        dbg_read_chk(A_STATUS, 32'h0000_0004, "rx_full_cleared");
        sreg_read_chk(64'h2222_2222_1111_1111, "dtr_rx_reread");
        dbg_read_chk(A_STATUS, 32'h0000_0024, "rx_undr_set");
        dbg_write(A_STATUS, 32'h20);
        // Host DTR_HI write in the same cycle as a core read: core sees old value
        sreg_exp_q.push_back(64'h2222_2222_1111_1111);
        @(negedge clk);
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b1; bus.dbg_addr = A_DTR_HI; bus.dbg_wdata = 32'h3333_3333;
        bus.sreg_rd_en = 1'b1; bus.sreg_rd_regnum = 3'd7; bus.sreg_rd_plevel = 2'd0;
        @(negedge clk);
        bus.dbg_req = 1'b0; bus.dbg_wr_rd = 1'b0; bus.sreg_rd_en = 1'b0;
        e = sreg_exp_q.pop_front();
        checks++;
        if (bus.sreg_rd_valid !== 1'b1 || bus.sreg_rd_val !== e) begin
            errors++;
            $display("FAIL dtr_rx_simul: valid=%b val=%h required valid=1 val=%h", bus.sreg_rd_valid, bus.sreg_rd_val, e);
        end
        $display("sreg read  val=%h exp=%h (simultaneous DTR_HI write)", bus.sreg_rd_val, e);
        dbg_read_chk(A_STATUS, 32'h0000_0025, "rx_simul_status");
        dbg_write(A_STATUS, 32'h20);
        sreg_read_chk(64'h3333_3333_1111_1111, "dtr_rx_new");
        dbg_read_chk(A_STATUS, 32'h0000_0004, "rx_final_status");
    endtask

    task automatic test_dtr_tx();
        logic [31:0] e;
        sreg_write(3'd7, 2'd0, 64'hAAAA_0000_BBBB_0000);
        dbg_read_chk(A_STATUS, 32'h0000_0006, "tx_full_set");
        sreg_write(3'd7, 2'd0, 64'h1111_2222_3333_4444);
        dbg_read_chk(A_STATUS, 32'h0000_0046, "tx_ovf_set");
        dbg_read_chk(A_TX_LO, 32'hBBBB_0000, "dtrtx_lo");
        dbg_read_chk(A_TX_HI, 32'hAAAA_0000, "dtrtx_hi");
        dbg_read_chk(A_STATUS, 32'h0000_0044, "tx_full_cleared");
        dbg_write(A_STATUS, 32'h70);
        dbg_read_chk(A_STATUS, 32'h0000_0004, "w1c_sticky");
        sreg_write(3'd3, 2'd0, 64'h5555_5555_5555_5555);
        sreg_write(3'd7, 2'd2, 64'h6666_6666_6666_6666);
        dbg_read_chk(A_STATUS, 32'h0000_0004, "sreg_wr_ignored");
        dbg_read_chk(A_TX_LO, 32'hBBBB_0000, "dtrtx_unchanged");
        // Core write with simultaneous host DTRTX_HI read: host sees old value
        sreg_write(3'd7, 2'd0, 64'h0101_0101_0202_0202);
        rd_exp_q.push_back(32'h0101_0101);
        @(negedge clk);
        bus.sreg_wr_en = 1'b1; bus.sreg_wr_regnum = 3'd7; bus.sreg_wr_plevel = 2'd0;
        bus.sreg_wr_val = 64'h0303_0303_0404_0404;
        bus.dbg_req = 1'b1; bus.dbg_wr_rd = 1'b0; bus.dbg_addr = A_TX_HI;
        @(negedge clk);
        bus.sreg_wr_en = 1'b0; bus.dbg_req = 1'b0;
        e = rd_exp_q.pop_front();
        checks++;
        if (bus.dbg_rd_ready !== 1'b1 || bus.dbg_rdata !== e) begin
            errors++;
            $display("FAIL dtrtx_simul: ready=%b rdata=%h required ready=1 rdata=%h", bus.dbg_rd_ready, bus.dbg_rdata, e);
        end
        $display("dbg read   addr=%0d data=%h exp=%h (simultaneous core write)", A_TX_HI, bus.dbg_rdata, e);
        dbg_read_chk(A_STATUS, 32'h0000_0006, "tx_simul_status");
        dbg_read_chk(A_TX_LO, 32'h0404_0404, "dtrtx_simul_lo");
        dbg_read_chk(A_TX_HI, 32'h0303_0303, "dtrtx_simul_hi");
        dbg_read_chk(A_STATUS, 32'h0000_0004, "tx_final_status");
    endtask

    task automatic test_reset_mid();
        bus.itr_ready = 1'b0;
        for (int i = 0; i < 3; i++) itr_push(32'h31 + 32'(i));
        sreg_read_chk(64'h3333_3333_1111_1111, "undr_before_reset");
        sreg_write(3'd7, 2'd0, 64'h7);
        sreg_write(3'd7, 2'd0, 64'h8);
        dbg_read_chk(A_STATUS, 32'h0000_0362, "status_before_reset");
        checks++;
        if (bus.itr_valid !== 1'b1) begin
            errors++; $display("FAIL itr_valid_before_reset: %b required 1", bus.itr_valid);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.itr_valid !== 1'b0 || bus.dbg_rdata !== 32'h0 || bus.sreg_rd_val !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: itr_valid=%b rdata=%h srval=%h required 0", bus.itr_valid, bus.dbg_rdata, bus.sreg_rd_val);
        end
        $display("reset pulsed mid-cycle");
        itr_exp_q.delete();
        model_itr_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.itr_valid !== 1'b0) begin
                errors++; $display("FAIL itr_valid_after_reset: %b required 0", bus.itr_valid);
            end
        end
        dbg_read_chk(A_STATUS, 32'h0000_0004, "status_after_reset");
        itr_push(32'h77);
        itr_drain_chk("itr_after_reset");
    endtask

    initial begin
        A_STATUS = 5'(DBGI_STATUS);   A_DTR_LO = 5'(DBGI_DTR_LO); A_DTR_HI = 5'(DBGI_DTR_HI);
        A_TX_LO  = 5'(DBGI_DTRTX_LO); A_TX_HI  = 5'(DBGI_DTRTX_HI); A_ITR3 = 5'(DBGI_ITR3);
        bus.dbg_req = 1'b0; bus.dbg_wr_rd = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.itr_ready = 1'b0;
        bus.sreg_rd_en = 1'b0; bus.sreg_rd_regnum = '0; bus.sreg_rd_plevel = '0;
        bus.sreg_wr_en = 1'b0; bus.sreg_wr_regnum = '0; bus.sreg_wr_plevel = '0; bus.sreg_wr_val = '0;
        test_reset();
        test_bank();
        test_itr_overflow();
        test_itr_push_pop_full();
        test_dtr_rx();
        test_dtr_tx();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_dbg_regs.md
CORE_DBG_REGS -- requirements
Module: core_dbg_regs

Interface
REQ-001 SHALL have parameter DBG_ADDR_WIDTH, default 5, debug register index width.
REQ-002 SHALL have parameter DBG_DATA_WIDTH, default 32, debug data width.
REQ-003 SHALL have parameter ITR_DEPTH, default 4, ITR FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter REG_WIDTH, default 64, sysreg width (= 2*DBG_DATA_WIDTH).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-006 SHALL have these debug-side ports:
- dbg_req (in, 1): request.
- dbg_wr_rd (in, 1): 1 = write, 0 = read.
- dbg_addr (in, DBG_ADDR_WIDTH): register index.
- dbg_wdata (in, DBG_DATA_WIDTH): write data.
- dbg_rdata (out, DBG_DATA_WIDTH): read data.
- dbg_rd_ready (out, 1): read-data-valid pulse.
REQ-007 SHALL have these fetch-side ports: itr_valid (out, 1), itr_insn (out, 32), itr_ready (in, 1).
REQ-008 SHALL have these sysreg-read ports: sreg_rd_en (in, 1), sreg_rd_regnum (in, 3), sreg_rd_plevel (in, 2), sreg_rd_valid (out, 1), sreg_rd_val (out, REG_WIDTH).
REQ-009 SHALL have these sysreg-write ports: sreg_wr_en (in, 1), sreg_wr_regnum (in, 3), sreg_wr_plevel (in, 2), sreg_wr_val (in, REG_WIDTH).

Function
REQ-010 SHALL complete a debug read one cycle after dbg_req&!dbg_wr_rd: dbg_rdata = selected register, and dbg_rd_ready high for exactly that one cycle.
REQ-011 SHALL store debug writes to plain indices into a 2^DBG_ADDR_WIDTH x DBG_DATA_WIDTH bank; reads of unwritten indices SHALL return 0.
REQ-012 SHALL push dbg_wdata into the ITR FIFO on a write to DBGI_ITR3 when the FIFO is not full.
REQ-013 SHALL drop an ITR3 write when the FIFO is full and set sticky STATUS.itr_ovf; a simultaneous pop SHALL free a slot and the push SHALL be accepted.
REQ-014 SHALL drive itr_valid = FIFO not empty and itr_insn = FIFO head; the FIFO SHALL pop on itr_valid&itr_ready; pointers SHALL wrap modulo ITR_DEPTH.
REQ-015 SHALL implement the DTR receive path as follows:
- A debug write to DBGI_DTR_HI sets rx_full.
- sreg_rd_en with regnum 7 / plevel 0 returns {DTR_HI, DTR_LO} with sreg_rd_valid one cycle later and clears rx_full.
- If rx_full is already 0 at that read, the read SHALL still return the value and SHALL set sticky rx_undr.
REQ-016 SHALL implement the DTR transmit path as follows:
- sreg_wr_en with regnum 7 / plevel 0 loads DTRTX_HI/LO and sets tx_full.
- If tx_full is already 1, the write SHALL be dropped and sticky tx_ovf set.
- A debug read of DBGI_DTRTX_HI clears tx_full.
REQ-017 SHALL NOT assert sreg_rd_valid for any other regnum/plevel, and SHALL ignore sreg writes to any other regnum/plevel.
REQ-018 SHALL resolve simultaneous events as follows:
- Debug DTR_HI write with a core DTR read: the core gets the old value and rx_full ends 1.
- Core DTRTX write with a debug DTRTX_HI read: the host gets the old value and tx_full ends 1.
REQ-019 SHALL report DBGI_STATUS (read) as:
- [0] rx_full; [1] tx_full; [2] itr_empty; [3] itr_full.
- [4] itr_ovf; [5] rx_undr; [6] tx_ovf.
- [15:8] ITR occupancy.
- All other bits 0.
REQ-020 SHALL treat a debug write to DBGI_STATUS as write-1-to-clear for bits [6:4] only.

Reset
REQ-021 SHALL, while rst_n is low, asynchronously clear:
- dbg_rdata, dbg_rd_ready, itr_valid, sreg_rd_valid, sreg_rd_val.
- FIFO pointers and count.
- rx_full, tx_full, and all sticky bits.
REQ-022 SHALL NOT reset the register bank or FIFO storage.
REQ-023 SHALL discard queued ITR entries on a reset asserted mid-operation, and SHALL produce no itr_valid until a new push.

Structure
REQ-024 SHALL place DBGI_STATUS, DBGI_DTR_LO, DBGI_DTR_HI, DBGI_DTRTX_LO, DBGI_DTRTX_HI, DBGI_ITR3, the STATUS bit positions and the EDBGDTR regnum/plevel (7/0) in package core.
REQ-025 SHALL implement the ITR queue as sub-module dbg_itr_fifo (parametrised width/depth, push/pop/full/empty/count).

Verification
REQ-026 SHALL cover the debug read path: write 0xDEADBEEF to index 9, then read 9 -> dbg_rdata=0xDEADBEEF with a single-cycle dbg_rd_ready exactly one cycle after the request.
REQ-027 SHALL cover ITR overflow:
- Stimulus: 5 ITR3 writes 0x1..0x5 with itr_ready=0 (ITR_DEPTH=4).
- Response: STATUS.itr_full=1, itr_ovf=1, occupancy 4.
- Then itr_ready=1 -> itr_insn 0x1,0x2,0x3,0x4 on consecutive cycles, then itr_valid=0.
REQ-028 SHALL cover the DTR receive path:
- Stimulus: DTR_LO=0x11111111, DTR_HI=0x22222222, then core read regnum7/pl0.
- Response: sreg_rd_val=0x2222222211111111, rx_full 1->0.
- A second read -> rx_undr=1.
REQ-029 SHALL cover the DTR transmit path:
- Stimulus: core write 0xAAAA0000BBBB0000, then a second core write, then host reads DTRTX_LO and DTRTX_HI.
- Response: tx_ovf=1; host reads 0xBBBB0000 then 0xAAAA0000; tx_full=0.
- Then write STATUS=0x70 -> bits [6:4] read 0.
REQ-030 SHALL cover reset mid-operation: 3 ITR entries queued, rst_n pulsed low mid-cycle -> itr_valid drops immediately, occupancy 0, all sticky bits 0.
